timer_axi_lite_core: RTL and testbench

//  AXI4-Lite slave timer peripheral for the riscv32im SoC, driven by the AXI-Lite master / CSR tester.

---
 rtl/timer_axi_lite_core_if.sv | 31 +++
 rtl/timer_axi_lite_core.sv | 194 +++++++++++++++++++
 tb/tb_timer_axi_lite_core.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_axi_lite_core_if.sv
// AXI4-Lite slave bus bundle for the timer peripheral (no strobes, full-word access).
// Latency: none, this is wiring only.
// Backpressure: standard valid/ready per channel; master drives valids, slave drives readies.
interface timer_axi_lite_core_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/timer_axi_lite_core.sv
// RISC-V machine timer: 64-bit MTIME with prescaler, 64-bit MTIMECMP, level interrupt, AXI4-Lite regs.
// Latency: write response and read data one cycle after the address handshake; interrupt one cycle after cause.
// Backpressure: one write and one read outstanding; AW/W and AR stall until B and R are accepted.
module timer_axi_lite_core #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned TICK_FREQ = 1_000_000,
  parameter logic [31:0] VERSION   = 32'h2024_0810
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  timer_axi_lite_core_if.slave   s_axi_lite,
  output logic                   interrupt
);

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;
  localparam logic [31:0] PRESCALE_RST = 32'(CLK_FREQ / TICK_FREQ - 1);

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t    w_state, w_next;
  r_state_t    r_state, r_next;
  logic        active;
  logic [63:0] mtime, mtime_nxt, mtime_inc;
  logic [63:0] mtimecmp, mtimecmp_nxt;
  logic [31:0] prescale, prescale_nxt;
  logic [31:0] pcnt, pcnt_nxt;
  logic        en, en_nxt, ie, ie_nxt;
  logic        tick, pend;
  logic        wr_fire, rd_fire, wr_ok, rd_ok;
  logic [7:0]  wr_sel;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q, rd_val;
  logic        unused_addr_bits;

  // Byte offset bits inside a word carry no meaning for full-word registers.
  assign unused_addr_bits = ^{s_axi_lite.awaddr[1:0], s_axi_lite.araddr[1:0]};

  // Keep the readies low while reset is asserted and for the first cycle after release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) active <= 1'b0;
    else          active <= 1'b1;
  end

  // Channel state registers; reset drops any in-flight transaction.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Write channel: AW and W accepted together only, then hold B until taken.
  always_comb begin
    w_next             = w_state;
    wr_fire            = 1'b0;
    s_axi_lite.awready = 1'b0;
    s_axi_lite.wready  = 1'b0;
    s_axi_lite.bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (active && s_axi_lite.awvalid && s_axi_lite.wvalid) begin
          s_axi_lite.awready = 1'b1;
          s_axi_lite.wready  = 1'b1;
          wr_fire            = 1'b1;
          w_next             = W_RESP;
        end
      end
      W_RESP: begin
        s_axi_lite.bvalid = 1'b1;
        if (s_axi_lite.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Read channel: accept AR when idle, then hold R until taken.
  always_comb begin
    r_next             = r_state;
    rd_fire            = 1'b0;
    s_axi_lite.arready = 1'b0;
    s_axi_lite.rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (active) begin
          s_axi_lite.arready = 1'b1;
          if (s_axi_lite.arvalid) begin
            rd_fire = 1'b1;
            r_next  = R_DATA;
          end
        end
      end
      R_DATA: begin
        s_axi_lite.rvalid = 1'b1;
        if (s_axi_lite.rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign wr_ok  = (s_axi_lite.awaddr[31:5] == 27'd0);
  assign rd_ok  = (s_axi_lite.araddr[31:5] == 27'd0);
  assign wr_sel = (wr_fire && wr_ok) ? (8'd1 << s_axi_lite.awaddr[4:2]) : 8'd0;
  assign pend   = (mtime >= mtimecmp);

  // Read data mux; out-of-window addresses return zero.
  always_comb begin
    rd_val = 32'd0;
    case (s_axi_lite.araddr[4:2])
      3'd0: rd_val = mtime[31:0];
      3'd1: rd_val = mtime[63:32];
      3'd2: rd_val = mtimecmp[31:0];
      3'd3: rd_val = mtimecmp[63:32];
      3'd4: rd_val = {30'd0, ie, en};
      3'd5: rd_val = {31'd0, pend};
      3'd6: rd_val = prescale;
      3'd7: rd_val = VERSION;
      default: rd_val = 32'd0;
    endcase
    if (!rd_ok) rd_val = 32'd0;
  end

  // Next-state of the timer: tick first, then bus writes override the written half only,
  // so a MTIME_HI write still keeps the low half counting and a MTIME_LO write never carries.
  always_comb begin
    tick         = en && (pcnt == prescale);
    mtime_inc    = mtime + {63'd0, tick};
    mtime_nxt    = mtime_inc;
    mtimecmp_nxt = mtimecmp;
    prescale_nxt = prescale;
    en_nxt       = en;
    ie_nxt       = ie;
    pcnt_nxt     = pcnt;
    if (en) pcnt_nxt = tick ? 32'd0 : pcnt + 32'd1;
    if (wr_sel[0]) mtime_nxt[31:0]     = s_axi_lite.wdata;
    if (wr_sel[1]) mtime_nxt[63:32]    = s_axi_lite.wdata;
    if (wr_sel[2]) mtimecmp_nxt[31:0]  = s_axi_lite.wdata;
    if (wr_sel[3]) mtimecmp_nxt[63:32] = s_axi_lite.wdata;
    if (wr_sel[4]) begin
      en_nxt = s_axi_lite.wdata[0];
      ie_nxt = s_axi_lite.wdata[1];
      if (!s_axi_lite.wdata[0]) pcnt_nxt = 32'd0;
    end
    if (wr_sel[6]) begin
      prescale_nxt = s_axi_lite.wdata;
      pcnt_nxt     = 32'd0;
    end
  end

  // Timer state and the registered interrupt, which looks at next-state values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mtime     <= 64'd0;
      mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      prescale  <= PRESCALE_RST;
      pcnt      <= 32'd0;
      en        <= 1'b0;
      ie        <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      mtime     <= mtime_nxt;
      mtimecmp  <= mtimecmp_nxt;
      prescale  <= prescale_nxt;
      pcnt      <= pcnt_nxt;
      en        <= en_nxt;
      ie        <= ie_nxt;
      interrupt <= ie_nxt && (mtime_nxt >= mtimecmp_nxt);
    end
  end

  // Response registers, captured at the address handshake and held until the next one.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
      rdata_q <= 32'd0;
    end else begin
      if (wr_fire) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (rd_fire) begin
        rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        rdata_q <= rd_val;
      end
    end
  end

  assign s_axi_lite.bresp = bresp_q;
  assign s_axi_lite.rresp = rresp_q;
  assign s_axi_lite.rdata = rdata_q;

endmodule

// File: tb/tb_timer_axi_lite_core.sv
// Directed bench for the AXI4-Lite machine timer.
// Latency: drives on posedge+1, samples after settling.
// Backpressure: exercises held B/R channels and a reset with a response pending.
module tb_timer_axi_lite_core;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic interrupt;
  int   checks = 0;
  int   errors = 0;

  timer_axi_lite_core_if bus();

  timer_axi_lite_core dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_axi_lite (bus),
    .interrupt  (interrupt)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
    int n;
    bus.awaddr = addr; bus.wdata = data;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    #1;
    n = 0;
    while (!bus.awready && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL aw_timeout addr=%h got no awready", addr); end
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL b_timeout addr=%h got no bvalid", addr); end
    resp = bus.bresp;
    @(posedge aclk); #1;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
    #1;
    n = 0;
    while (!bus.arready && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL ar_timeout addr=%h got no arready", addr); end
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL r_timeout addr=%h got no rvalid", addr); end
    data = bus.rdata; resp = bus.rresp;
    @(posedge aclk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_val [8];
    logic [31:0] d;
    logic [1:0]  r;
    exp_val = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h63, 32'h2024_0810};
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    aresetn = 1'b0;
    tick(3);
    checks++;
    if ({bus.arready, bus.awready, bus.wready, bus.bvalid, bus.rvalid, interrupt} !== 6'b0) begin
      errors++;
      $display("FAIL reset_hs got ar/aw/w/b/r/irq=%b required 000000",
               {bus.arready, bus.awready, bus.wready, bus.bvalid, bus.rvalid, interrupt});
    end
    checks++;
    if ({bus.rdata, bus.rresp, bus.bresp} !== 36'd0) begin
      errors++;
      $display("FAIL reset_resp got rdata=%h rresp=%b bresp=%b required 0", bus.rdata, bus.rresp, bus.bresp);
    end
    aresetn = 1'b1;
    tick(2);
    for (int i = 0; i < 8; i++) begin
      axi_read(32'(i * 4), d, r);
      checks++;
      if (d !== exp_val[i] || r !== 2'b00) begin
        errors++;
        $display("FAIL reset_reg off=%h got %h/%b required %h/00", i * 4, d, r, exp_val[i]);
      end
    end
  endtask

  task automatic test_carry();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h18, 32'h0, r);
    axi_write(32'h00, 32'hFFFF_FFFE, r);
    axi_write(32'h04, 32'h0, r);
    axi_write(32'h10, 32'h1, r);
    tick(4);
    axi_read(32'h04, d, r);
    checks++;
    if (d !== 32'h1 || r !== 2'b00) begin
      errors++; $display("FAIL carry_hi got %h/%b required 00000001/00", d, r);
    end
    axi_write(32'h10, 32'h0, r);
    axi_write(32'h00, 32'h5, r);
    axi_write(32'h04, 32'h7, r);
    tick(5);
    axi_read(32'h00, d, r);
    checks++;
    if (d !== 32'h5) begin errors++; $display("FAIL frozen_lo got %h required 00000005", d); end
    axi_read(32'h04, d, r);
    checks++;
    if (d !== 32'h7) begin errors++; $display("FAIL frozen_hi got %h required 00000007", d); end
  endtask

  task automatic test_prescale();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h18, 32'h3, r);
    axi_write(32'h00, 32'h0, r);
    axi_write(32'h04, 32'h0, r);
    axi_write(32'h10, 32'h1, r);
    tick(36);
    axi_write(32'h10, 32'h0, r);
    axi_read(32'h00, d, r);
    checks++;
    if (d !== 32'd9) begin errors++; $display("FAIL prescale_div4 got %0d required 9", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic [1:0]  r;
    int n;
    axi_write(32'h18, 32'h0, r);
    axi_write(32'h00, 32'h0, r);
    axi_write(32'h04, 32'h0, r);
    axi_write(32'h0C, 32'h0, r);
    axi_write(32'h08, 32'd100, r);
    axi_write(32'h10, 32'h3, r);
    checks++;
    if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_early got %b required 0", interrupt); end
    n = 0;
    while (!interrupt && n < 300) begin @(posedge aclk); #1; n++; end
    checks++;
    if (n !== 99) begin errors++; $display("FAIL irq_rise_delay got %0d cycles required 99", n); end
    axi_read(32'h14, d, r);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL status_pend got %h required 00000001", d); end
    axi_write(32'h08, 32'hFFFF_FFFF, r);
    checks++;
    if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_fall_cmp got %b required 0", interrupt); end
    axi_read(32'h14, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL status_clear got %h required 00000000", d); end
    axi_write(32'h08, 32'h0, r);
    checks++;
    if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_rise_cmp0 got %b required 1", interrupt); end
    axi_write(32'h10, 32'h1, r);
    checks++;
    if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_ie_clear got %b required 0", interrupt); end
    axi_read(32'h14, d, r);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL status_ie_off got %h required 00000001", d); end
  endtask

  task automatic test_slverr();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h10, 32'h0, r);
    axi_write(32'h00, 32'h1234, r);
    axi_write(32'h04, 32'h0, r);
    axi_read(32'h40, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL rd_slverr got %h/%b required 00000000/10", d, r); end
    axi_write(32'h40, 32'hDEAD, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL wr_slverr got %b required 10", r); end
    axi_read(32'h00, d, r);
    checks++;
    if (d !== 32'h1234) begin errors++; $display("FAIL slverr_nochange got %h required 00001234", d); end
    axi_write(32'h1C, 32'h0, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL wr_ro_resp got %b required 00", r); end
    axi_read(32'h1C, d, r);
    checks++;
    if (d !== 32'h2024_0810) begin errors++; $display("FAIL version_ro got %h required 20240810", d); end
    axi_write(32'h14, 32'h0, r);
    axi_read(32'h14, d, r);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL status_ro got %h required 00000001", d); end
    axi_write(32'h10, 32'hFFFF_FFFC, r);
    axi_read(32'h10, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL control_mask got %h required 00000000", d); end
  endtask

  task automatic test_backpressure();
    int n;
    bus.awaddr = 32'h18; bus.wdata = 32'h55; bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    #1;
    n = 0;
    while (!bus.awready && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL bp_aw_timeout got no awready"); end
    @(posedge aclk); #1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || bus.awready !== 1'b0 || bus.wready !== 1'b0) begin
        errors++;
        $display("FAIL bp_b_hold cyc=%0d got bvalid=%b bresp=%b awready=%b wready=%b required 1/00/0/0",
                 i, bus.bvalid, bus.bresp, bus.awready, bus.wready);
      end
      @(posedge aclk); #1;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    @(posedge aclk); #1;
    checks++;
    if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL bp_b_release got bvalid=%b required 0", bus.bvalid); end

    bus.araddr = 32'h18; bus.arvalid = 1'b1; bus.rready = 1'b0;
    #1;
    n = 0;
    while (!bus.arready && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL bp_ar_timeout got no arready"); end
    @(posedge aclk); #1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h55 || bus.rresp !== 2'b00 || bus.arready !== 1'b0) begin
        errors++;
        $display("FAIL bp_r_hold cyc=%0d got rvalid=%b rdata=%h rresp=%b arready=%b required 1/00000055/00/0",
                 i, bus.rvalid, bus.rdata, bus.rresp, bus.arready);
      end
      @(posedge aclk); #1;
    end
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    @(posedge aclk); #1;
    checks++;
    if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL bp_r_release got rvalid=%b required 0", bus.rvalid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [1:0]  r;
    bus.awaddr = 32'h08; bus.wdata = 32'hAAAA; bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    bus.araddr = 32'h18; bus.arvalid = 1'b1; bus.rready = 1'b1;
    #1;
    checks++;
    if (bus.awready !== 1'b1 || bus.arready !== 1'b1) begin
      errors++; $display("FAIL dual_ready got awready=%b arready=%b required 1/1", bus.awready, bus.arready);
    end
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    checks++;
    if (bus.bvalid !== 1'b1 || bus.rvalid !== 1'b1 || bus.rdata !== 32'h55) begin
      errors++;
      $display("FAIL dual_resp got bvalid=%b rvalid=%b rdata=%h required 1/1/00000055", bus.bvalid, bus.rvalid, bus.rdata);
    end
    @(posedge aclk); #1;
    checks++;
    if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0) begin
      errors++; $display("FAIL dual_done got bvalid=%b rvalid=%b required 0/0", bus.bvalid, bus.rvalid);
    end
    axi_read(32'h08, d, r);
    checks++;
    if (d !== 32'hAAAA) begin errors++; $display("FAIL dual_wdata got %h required 0000AAAA", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_val [4];
    logic [31:0] exp_addr [4];
    logic [31:0] d;
    logic [1:0]  r;
    int n;
    exp_addr = '{32'h18, 32'h10, 32'h08, 32'h00};
    exp_val  = '{32'h63, 32'h0, 32'hFFFF_FFFF, 32'h0};
    axi_write(32'h08, 32'h0, r);
    axi_write(32'h10, 32'h2, r);
    checks++;
    if (interrupt !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b required 1", interrupt); end
    bus.awaddr = 32'h18; bus.wdata = 32'h7; bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    #1;
    n = 0;
    while (!bus.awready && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL rst_aw_timeout got no awready"); end
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    checks++;
    if (bus.bvalid !== 1'b1) begin errors++; $display("FAIL rst_pending got bvalid=%b required 1", bus.bvalid); end
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if (bus.bvalid !== 1'b0 || interrupt !== 1'b0) begin
      errors++; $display("FAIL rst_async got bvalid=%b irq=%b required 0/0", bus.bvalid, interrupt);
    end
    bus.bready = 1'b1;
    tick(2);
    aresetn = 1'b1;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      axi_read(exp_addr[i], d, r);
      checks++;
      if (d !== exp_val[i]) begin
        errors++; $display("FAIL rst_state addr=%h got %h required %h", exp_addr[i], d, exp_val[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_prescale();
    test_irq();
    test_slverr();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
